soc_pwrmgr: RTL and testbench
=============================

SOC_PWRMGR -- requirements
Module: soc_pwrmgr

Interface
REQ-001 SHALL have parameter NUM_WAKE, default 2, number of wake-source inputs (1..8).
REQ-002 SHALL have parameter WAKE_MASK, default all ones, NUM_WAKE bits; bit=1 enables that wake source.
REQ-003 SHALL have parameter WAKE_ACT_LOW, default all ones, NUM_WAKE bits; bit=1 means source active when low.
REQ-004 SHALL have parameter RESET_HOLD, default 16, cycles SoC reset held after wake (>=1).
REQ-005 SHALL have parameter DRAIN_TIMEOUT, default 1024, max cycles spent draining before power-off (>=1).
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 resetn  input  1  reset, synchronous, active-low.
REQ-008 wake_in  input  NUM_WAKE  asynchronous wake sources (e.g. bit0 = uart_cts).
REQ-009 poweroff_rq  input  1  power-off request from SoC.
REQ-010 tx_idle  input  1  SoC UART transmitter idle.
REQ-011 soc_tx, soc_rts  input  1 each  SoC UART outputs.
REQ-012 soc_resetn  output  1  active-low reset to SoC.
REQ-013 uart_tx, uart_rts  output  1 each  gated pad-side UART outputs.
REQ-014 state  output  2  current state: OFF=0, HOLD=1, RUN=2, DRAIN=3.
REQ-015 wake_cause  output  NUM_WAKE  snapshot of active enabled sources at last wake.
REQ-016 boot_count  output  8  number of completed boots, wraps 255->0.

Function
REQ-017 Each wake_in bit SHALL pass a 2-flop synchronizer, then polarity-normalise per WAKE_ACT_LOW, then AND with WAKE_MASK, giving wake_act.
REQ-018 Block SHALL hold an arm flag; wake from OFF only when armed and any wake_act bit high.
REQ-019 OFF: armed & |wake_act -> HOLD; wake_cause <= wake_act; hold counter cleared.
REQ-020 OFF, not armed: arm flag SHALL set on first cycle with wake_act all zero; no transition that cycle.
REQ-021 HOLD: counter increments each cycle; after exactly RESET_HOLD cycles in HOLD -> RUN; boot_count +1 on that transition.
REQ-022 RUN: poweroff_rq high -> DRAIN, drain counter cleared; otherwise stay.
REQ-023 DRAIN: tx_idle high, or DRAIN_TIMEOUT cycles elapsed in DRAIN -> OFF, arm flag cleared.
REQ-024 poweroff_rq SHALL be ignored in OFF, HOLD, DRAIN; wake_act ignored outside OFF.
REQ-025 soc_resetn SHALL be 1 iff resetn=1 and state is RUN or DRAIN (decoded from state register only).
REQ-026 uart_tx/uart_rts SHALL equal soc_tx/soc_rts in RUN and DRAIN, else constant 1.
REQ-027 Latency: wake pin stable before edge E0 -> state HOLD after edge E2 -> RUN after edge E2+RESET_HOLD.
REQ-028 Re-arm rule SHALL prevent reboot loops: a wake source held active through power-off does not restart the SoC until released.

Reset
REQ-029 On resetn=0 at a rising edge: state=OFF, arm flag=1, counters=0, wake_cause=0, boot_count=0, synchronizers=0 (inactive-equivalent not required).
REQ-030 During reset soc_resetn=0, uart_tx=1, uart_rts=1, independent of any input.
REQ-031 Reset asserted mid-HOLD, RUN or DRAIN SHALL abort immediately to OFF with the REQ-029 values.

Verification
REQ-032 Defaults, wake_in[0] driven low after reset -> state HOLD 3 edges later, soc_resetn rises 16 cycles after, boot_count=1, wake_cause=2'b01.
REQ-033 In RUN, poweroff_rq pulse with tx_idle=0 for 5 cycles then 1 -> DRAIN 6 cycles, then OFF, soc_resetn=0, uart_tx=1.
REQ-034 DRAIN with tx_idle held 0, DRAIN_TIMEOUT=8 -> OFF after exactly 8 cycles in DRAIN.
REQ-035 wake_in[0] held low across power-off -> stays OFF; release 1 cycle then reassert -> new boot, boot_count=2.
REQ-036 WAKE_MASK=2'b10, wake_in[0] low -> no wake; wake_in[1] low -> wake, wake_cause=2'b10.
REQ-037 resetn low for 1 cycle mid-RUN -> state=OFF, boot_count=0, soc_resetn=0 next cycle; then immediate rewake if wake source active.

Source files
------------

// File: rtl/soc_pwrmgr_if.sv
// Power-manager bundle: wake pins, power-off handshake, UART gating, status.
// master = SoC/board side (drives inputs), slave = soc_pwrmgr.
interface soc_pwrmgr_if #(
    parameter int NUM_WAKE = 2
);
    logic [NUM_WAKE-1:0] wake_in;
    logic                poweroff_rq;
    logic                tx_idle;
    logic                soc_tx;
    logic                soc_rts;
    logic                soc_resetn;
    logic                uart_tx;
    logic                uart_rts;
    logic [1:0]          state;
    logic [NUM_WAKE-1:0] wake_cause;
    logic [7:0]          boot_count;

    modport master (
        output wake_in, poweroff_rq, tx_idle, soc_tx, soc_rts,
        input  soc_resetn, uart_tx, uart_rts, state, wake_cause, boot_count
    );

    modport slave (
        input  wake_in, poweroff_rq, tx_idle, soc_tx, soc_rts,
        output soc_resetn, uart_tx, uart_rts, state, wake_cause, boot_count
    );
endinterface

// File: rtl/soc_pwrmgr.sv
// SoC power manager: wake-pin sync/arm, reset hold, drain-then-off sequencing.
// Ports: clk, resetn (sync, active-low), bus (soc_pwrmgr_if.slave).
module soc_pwrmgr #(
    parameter int                  NUM_WAKE      = 2,
    parameter logic [NUM_WAKE-1:0] WAKE_MASK     = '1,
    parameter logic [NUM_WAKE-1:0] WAKE_ACT_LOW  = '1,
    parameter int                  RESET_HOLD    = 16,
    parameter int                  DRAIN_TIMEOUT = 1024
) (
    input logic         clk,
    input logic         resetn,
    soc_pwrmgr_if.slave bus
);
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    logic [NUM_WAKE-1:0] sync1;
    logic [NUM_WAKE-1:0] sync2;
    logic [NUM_WAKE-1:0] wake_act;
    state_t              st;
    logic                armed;
    logic [HW-1:0]       hold_cnt;
    logic [DW-1:0]       drain_cnt;
    logic [NUM_WAKE-1:0] cause;
    logic [7:0]          boots;
    logic                live;

    // Synchronizer flops carry the polarity-normalised level (XOR with a
    // constant is a wire or inverter), so their cleared value reads as
    // "inactive" and reset never fabricates a wake event.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.wake_in ^ WAKE_ACT_LOW;
            sync2 <= sync1;
        end
    end

    assign wake_act = sync2 & WAKE_MASK;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st        <= OFF;
            armed     <= 1'b1;
            hold_cnt  <= '0;
            drain_cnt <= '0;
            cause     <= '0;
            boots     <= '0;
        end else begin
            unique case (st)
                OFF: begin
                    // Disarmed after a power-off: wait for all sources to
                    // go quiet once, so a stuck pin cannot reboot-loop.
                    if (!armed) begin
                        if (wake_act == '0) armed <= 1'b1;
                    end else if (|wake_act) begin
                        st       <= HOLD;
                        cause    <= wake_act;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        st    <= RUN;
                        boots <= boots + 8'd1;
                    end
                end
                RUN: begin
                    if (bus.poweroff_rq) begin
                        st        <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (bus.tx_idle || drain_cnt == DRAIN_LAST) begin
                        st    <= OFF;
                        armed <= 1'b0;
                    end
                end
            endcase
        end
    end

    // RUN and DRAIN are the only states with st[1] set.
    assign live           = resetn & st[1];
    assign bus.soc_resetn = live;
    assign bus.uart_tx    = live ? bus.soc_tx  : 1'b1;
    assign bus.uart_rts   = live ? bus.soc_rts : 1'b1;
    assign bus.state      = st;
    assign bus.wake_cause = cause;
    assign bus.boot_count = boots;
endmodule

// File: tb/tb_soc_pwrmgr.sv
// Bench for soc_pwrmgr: two instances (mask 11 / timeout 8, and mask 10)
// checked every cycle against a behavioural model plus literal checkpoints.
module tb_soc_pwrmgr;
    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] wake;
    logic       prq;
    logic       idle;
    logic       soc_tx;
    logic       soc_rts;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    soc_pwrmgr_if #(.NUM_WAKE(2)) ifa ();
    soc_pwrmgr_if #(.NUM_WAKE(2)) ifb ();

    assign ifa.wake_in     = wake;
    assign ifa.poweroff_rq = prq;
    assign ifa.tx_idle     = idle;
    assign ifa.soc_tx      = soc_tx;
    assign ifa.soc_rts     = soc_rts;
    assign ifb.wake_in     = wake;
    assign ifb.poweroff_rq = prq;
    assign ifb.tx_idle     = idle;
    assign ifb.soc_tx      = soc_tx;
    assign ifb.soc_rts     = soc_rts;

    soc_pwrmgr #(
        .NUM_WAKE(2), .WAKE_MASK(2'b11), .WAKE_ACT_LOW(2'b11),
        .RESET_HOLD(16), .DRAIN_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa)
    );

    soc_pwrmgr #(
        .NUM_WAKE(2), .WAKE_MASK(2'b10), .WAKE_ACT_LOW(2'b11),
        .RESET_HOLD(16), .DRAIN_TIMEOUT(1024)
    ) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Model: phase number, cycles spent in the phase, and a raw pin
    // history two edges deep (all sources are active-low here).
    typedef struct {
        int         st;
        bit         armed;
        int         n;
        logic [1:0] cause;
        int         boots;
        logic [1:0] h1;
        logic [1:0] h2;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, logic rst, logic [1:0] pin,
                                  logic rq, logic idl, logic [1:0] mask,
                                  int hold, int tmo);
        mdl_t r = m;
        logic [1:0] act;
        if (!rst) begin
            r.st = 0; r.armed = 1; r.n = 0; r.cause = 2'b00;
            r.boots = 0; r.h1 = 2'b11; r.h2 = 2'b11;
            return r;
        end
        act = ~m.h2 & mask;
        r.h1 = pin;
        r.h2 = m.h1;
        case (m.st)
            0: begin
                if (!m.armed) begin
                    if (act == 2'b00) r.armed = 1;
                end else if (act != 2'b00) begin
                    r.st = 1; r.cause = act; r.n = 0;
                end
            end
            1: begin
                r.n = m.n + 1;
                if (r.n == hold) begin
                    r.st = 2; r.boots = (m.boots + 1) % 256;
                end
            end
            2: if (rq) begin r.st = 3; r.n = 0; end
            3: begin
                r.n = m.n + 1;
                if (idl || r.n == tmo) begin r.st = 0; r.armed = 0; end
            end
            default: ;
        endcase
        return r;
    endfunction

    mdl_t ma;
    mdl_t mb;
    bit   mvalid = 0;

    task automatic cmp(input string tag, input mdl_t m, input logic [1:0] st,
                       input logic srn, input logic utx, input logic urts,
                       input logic [1:0] cs, input logic [7:0] bc);
        logic lv;
        lv = resetn && m.st >= 2;
        chk({tag, ".state"}, 32'(st), 32'(m.st));
        chk({tag, ".soc_resetn"}, 32'(srn), 32'(lv));
        chk({tag, ".uart_tx"}, 32'(utx), 32'(lv ? soc_tx : 1'b1));
        chk({tag, ".uart_rts"}, 32'(urts), 32'(lv ? soc_rts : 1'b1));
        chk({tag, ".wake_cause"}, 32'(cs), 32'(m.cause));
        chk({tag, ".boot_count"}, 32'(bc), 32'(m.boots));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            ma = step(ma, resetn, wake, prq, idle, 2'b11, 16, 8);
            mb = step(mb, resetn, wake, prq, idle, 2'b10, 16, 1024);
            if (!resetn) mvalid = 1;
            #1;
            if (mvalid) begin
                cmp("a", ma, ifa.state, ifa.soc_resetn, ifa.uart_tx,
                    ifa.uart_rts, ifa.wake_cause, ifa.boot_count);
                cmp("b", mb, ifb.state, ifb.soc_resetn, ifb.uart_tx,
                    ifb.uart_rts, ifb.wake_cause, ifb.boot_count);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; wake = 2'b11; prq = 1'b0; idle = 1'b0;
        soc_tx = 1'b0; soc_rts = 1'b0;
        cyc(3);
        chk("rst_state", 32'(ifa.state), 32'd0);
        chk("rst_srn", 32'(ifa.soc_resetn), 32'd0);
        chk("rst_tx", 32'(ifa.uart_tx), 32'd1);
        chk("rst_rts", 32'(ifa.uart_rts), 32'd1);
        chk("rst_boot", 32'(ifa.boot_count), 32'd0);
        resetn = 1'b1; soc_tx = 1'b1; soc_rts = 1'b1;
        cyc(1);

        // first wake on bit0
        wake = 2'b10;
        cyc(2);
        chk("wake_e1", 32'(ifa.state), 32'd0);
        cyc(1);
        chk("wake_e2", 32'(ifa.state), 32'd1);
        cyc(15);
        chk("hold_end", 32'(ifa.state), 32'd1);
        chk("hold_srn", 32'(ifa.soc_resetn), 32'd0);
        cyc(1);
        chk("run", 32'(ifa.state), 32'd2);
        chk("run_srn", 32'(ifa.soc_resetn), 32'd1);
        chk("boot1", 32'(ifa.boot_count), 32'd1);
        chk("cause1", 32'(ifa.wake_cause), 32'd1);
        chk("b_masked", 32'(ifb.state), 32'd0);

        // pass-through, then drain ended by tx_idle in cycle 6
        wake = 2'b11; soc_tx = 1'b0; soc_rts = 1'b0;
        cyc(2);
        chk("run_tx", 32'(ifa.uart_tx), 32'd0);
        chk("run_rts", 32'(ifa.uart_rts), 32'd0);
        prq = 1'b1;
        cyc(1);
        prq = 1'b0;
        chk("drain_in", 32'(ifa.state), 32'd3);
        cyc(4);
        chk("drain_c5", 32'(ifa.state), 32'd3);
        cyc(1);
        idle = 1'b1;
        chk("drain_c6", 32'(ifa.state), 32'd3);
        cyc(1);
        idle = 1'b0;
        chk("off", 32'(ifa.state), 32'd0);
        chk("off_srn", 32'(ifa.soc_resetn), 32'd0);
        chk("off_tx", 32'(ifa.uart_tx), 32'd1);

        // second boot, then drain by timeout with wake held active
        wake = 2'b10;
        cyc(19);
        chk("boot2_run", 32'(ifa.state), 32'd2);
        chk("boot2", 32'(ifa.boot_count), 32'd2);
        prq = 1'b1;
        cyc(1);
        prq = 1'b0;
        chk("to_in", 32'(ifa.state), 32'd3);
        cyc(7);
        chk("to_c8", 32'(ifa.state), 32'd3);
        cyc(1);
        chk("to_off", 32'(ifa.state), 32'd0);
        cyc(10);
        chk("held_off", 32'(ifa.state), 32'd0);

        // one-cycle release re-arms
        wake = 2'b11;
        cyc(1);
        wake = 2'b10;
        cyc(2);
        chk("rearm_wait", 32'(ifa.state), 32'd0);
        cyc(1);
        chk("rearm_hold", 32'(ifa.state), 32'd1);
        cyc(16);
        chk("boot3_run", 32'(ifa.state), 32'd2);
        chk("boot3", 32'(ifa.boot_count), 32'd3);

        // reset mid-RUN, then immediate rewake
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        chk("mrst_state", 32'(ifa.state), 32'd0);
        chk("mrst_boot", 32'(ifa.boot_count), 32'd0);
        chk("mrst_cause", 32'(ifa.wake_cause), 32'd0);
        cyc(2);
        chk("rewake_wait", 32'(ifa.state), 32'd0);
        cyc(1);
        chk("rewake", 32'(ifa.state), 32'd1);

        // masked instance wakes only on bit1
        wake = 2'b01;
        cyc(3);
        chk("b_hold", 32'(ifb.state), 32'd1);
        cyc(16);
        chk("b_run", 32'(ifb.state), 32'd2);
        chk("b_cause", 32'(ifb.wake_cause), 32'd2);
        chk("b_boot", 32'(ifb.boot_count), 32'd1);
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
